// File: rtl/mem_access_ctrl.sv
// Load/store initiator toward a word-wide data memory: aligns requests, performs
// read-modify-write for sub-word stores and sign/zero-extends sub-word loads.
module mem_access_ctrl #(
   parameter int ADDR_WIDTH  = 32,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  we,
   input  logic [1:0]            size,
   input  logic                  sign_ext,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [31:0]           rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [31:0]           write_data,
   input  logic [31:0]           read_data
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [1:0]            size_q, size_d;
   logic                  sext_q, sext_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           word_q, word_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [3:0]            wait_q, wait_d;

   logic                  req_bad;
   logic [4:0]            byte_sh;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [31:0]           ld_ext;
   logic [3:0]            lane_sel;
   logic [31:0]           merged;

   // Rejected requests: illegal size or an address not aligned to the access size.
   always_comb begin
      req_bad = 1'b0;
      case (size)
         SZ_HALF: req_bad = addr[0];
         SZ_WORD: req_bad = (addr[1:0] != 2'b00);
         SZ_BYTE: req_bad = 1'b0;
         default: req_bad = 1'b1;
      endcase
   end

   always_comb begin
      byte_sh = {addr_q[1:0], 3'b000};
      ld_byte = read_data[byte_sh +: 8];
      ld_half = addr_q[1] ? read_data[31:16] : read_data[15:0];
      case (size_q)
         SZ_BYTE: ld_ext = {{24{sext_q & ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_ext = {{16{sext_q & ld_half[15]}}, ld_half};
         default: ld_ext = read_data;
      endcase
   end

   // Store merge: each byte lane takes store data when selected, else keeps the captured word.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] src_byte;

         always_comb begin
            case (size_q)
               SZ_BYTE: begin
                  lane_sel[gi] = (addr_q[1:0] == 2'(gi));
                  src_byte     = wdata_q[7:0];
               end
               SZ_HALF: begin
                  lane_sel[gi] = (addr_q[1] == 1'(gi / 2));
                  src_byte     = wdata_q[8*(gi%2) +: 8];
               end
               default: begin
                  lane_sel[gi] = 1'b1;
                  src_byte     = wdata_q[8*gi +: 8];
               end
            endcase
         end

         assign merged[8*gi +: 8] = lane_sel[gi] ? src_byte : word_q[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      size_d  = size_q;
      sext_d  = sext_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      rdata_d = rdata_q;
      wait_d  = wait_q;

      case (state_q)
         S_IDLE: begin
            wait_d = 4'd0;
            if (start) begin
               addr_d  = addr;
               we_d    = we;
               size_d  = size;
               sext_d  = sign_ext;
               wdata_d = wdata;
               if (req_bad) begin
                  state_d = S_ERR;
               end else if (we && (size == SZ_WORD)) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            if (wait_q == WAIT_LAST) begin
               wait_d = 4'd0;
               word_d = read_data;
               if (we_q) begin
                  state_d = S_WRITE;
               end else begin
                  rdata_d = ld_ext;
                  state_d = S_DONE;
               end
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         S_WRITE: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         sext_q  <= 1'b0;
         wdata_q <= 32'd0;
         word_q  <= 32'd0;
         rdata_q <= 32'd0;
         wait_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
         wait_q  <= wait_d;
      end
   end

   // Outputs decode the state register directly so reset removes the strobes immediately.
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE) || (state_q == S_ERR);
   assign err        = (state_q == S_ERR);
   assign mem_read   = (state_q == S_READ);
   assign mem_write  = (state_q == S_WRITE);
   assign address    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign write_data = (state_q == S_WRITE) ? merged : 32'd0;
   assign rdata      = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES 0 and 2), each with its own
// memory; expected responses are queued at issue time and compared at done.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start0, start2, we, sign_ext;
   logic [1:0]  size;
   logic [31:0] addr, wdata;

   logic        busy0, done0, err0, mem_read0, mem_write0;
   logic [31:0] rdata0, address0, write_data0, read_data0;
   logic        busy2, done2, err2, mem_read2, mem_write2;
   logic [31:0] rdata2, address2, write_data2, read_data2;

   mem_access_ctrl #(.ADDR_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .we(we), .size(size),
      .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy0), .done(done0),
      .err(err0), .rdata(rdata0), .mem_read(mem_read0), .mem_write(mem_write0),
      .address(address0), .write_data(write_data0), .read_data(read_data0)
   );

   mem_access_ctrl #(.ADDR_WIDTH(32), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .we(we), .size(size),
      .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy2), .done(done2),
      .err(err2), .rdata(rdata2), .mem_read(mem_read2), .mem_write(mem_write2),
      .address(address2), .write_data(write_data2), .read_data(read_data2)
   );

   // Memory models with a bench-side preload port.
   logic [31:0] mem0 [0:15];
   logic [31:0] mem2 [0:15];
   logic        pl_en0, pl_en2;
   logic [3:0]  pl_idx;
   logic [31:0] pl_val;

   always @(posedge clk) begin
      if (pl_en0) mem0[pl_idx] <= pl_val;
      else if (mem_write0) mem0[address0[5:2]] <= write_data0;
   end
   always @(posedge clk) begin
      if (pl_en2) mem2[pl_idx] <= pl_val;
      else if (mem_write2) mem2[address2[5:2]] <= write_data2;
   end
   assign read_data0 = mem0[address0[5:2]];
   assign read_data2 = mem2[address2[5:2]];

   // Selected-instance view used by the request task.
   logic        sel_d2;
   logic        s_busy, s_done, s_err, s_mem_read, s_mem_write;
   logic [31:0] s_rdata, s_address, s_write_data;
   assign s_busy       = sel_d2 ? busy2       : busy0;
   assign s_done       = sel_d2 ? done2       : done0;
   assign s_err        = sel_d2 ? err2        : err0;
   assign s_mem_read   = sel_d2 ? mem_read2   : mem_read0;
   assign s_mem_write  = sel_d2 ? mem_write2  : mem_write0;
   assign s_rdata      = sel_d2 ? rdata2      : rdata0;
   assign s_address    = sel_d2 ? address2    : address0;
   assign s_write_data = sel_d2 ? write_data2 : write_data0;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
      logic [31:0] wd;
      logic [31:0] adr;
      logic [7:0]  lat;
      logic [7:0]  nrd;
      logic [7:0]  nwr;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] shadow [0:1][0:15];
   logic [31:0] last_rdata [0:1];
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] extend(input logic [31:0] wrd, input logic [31:0] a,
                                          input logic [1:0] sz, input bit sx);
      logic [31:0] v;
      case (sz)
         2'd0: begin
            v = (wrd >> (int'(a[1:0]) * 8)) & 32'h0000_00FF;
            if (sx && v[7]) v = v | 32'hFFFF_FF00;
         end
         2'd1: begin
            v = (wrd >> (int'(a[1]) * 16)) & 32'h0000_FFFF;
            if (sx && v[15]) v = v | 32'hFFFF_0000;
         end
         default: v = wrd;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] wrd, input logic [31:0] a,
                                         input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] m;
      int          sh;
      case (sz)
         2'd0: begin
            sh = int'(a[1:0]) * 8;
            m  = 32'h0000_00FF << sh;
            return (wrd & ~m) | ((d & 32'h0000_00FF) << sh);
         end
         2'd1: begin
            sh = int'(a[1]) * 16;
            m  = 32'h0000_FFFF << sh;
            return (wrd & ~m) | ((d & 32'h0000_FFFF) << sh);
         end
         default: return d;
      endcase
   endfunction

   task automatic preload(input bit d2, input int idx, input logic [31:0] v);
      @(negedge clk);
      pl_idx = 4'(idx);
      pl_val = v;
      if (d2) pl_en2 = 1'b1;
      else    pl_en0 = 1'b1;
      shadow[d2][idx] = v;
      @(negedge clk);
      pl_en0 = 1'b0;
      pl_en2 = 1'b0;
   endtask

   // Issue one request, watch strobes until done, compare against the queued expectation.
   // poke=1 pulses a spurious word store while the controller is busy.
   task automatic do_req(input bit d2, input string tag, input bit w, input logic [1:0] sz,
                         input bit sx, input logic [31:0] a, input logic [31:0] wd, input bit poke);
      exp_t        e, got;
      bit          legal, both, fin;
      logic [31:0] wrd, seen_wd, seen_adr, memw;
      int          wc, cyc, nrd, nwr;

      wc    = d2 ? 2 : 0;
      legal = (sz != 2'd3) && !(sz == 2'd1 && a[0]) && !(sz == 2'd2 && a[1:0] != 2'd0);
      wrd   = shadow[d2][a[5:2]];
      e     = '0;
      e.adr = {a[31:2], 2'b00};
      if (!legal) begin
         e.err = 1'b1; e.lat = 8'd1; e.rdata = last_rdata[d2];
      end else if (w && sz == 2'd2) begin
         e.lat = 8'd2; e.nwr = 8'd1; e.wd = wd; e.rdata = last_rdata[d2];
         shadow[d2][a[5:2]] = wd;
      end else if (w) begin
         e.lat = 8'(3 + wc); e.nrd = 8'(1 + wc); e.nwr = 8'd1;
         e.wd = merge(wrd, a, sz, wd); e.rdata = last_rdata[d2];
         shadow[d2][a[5:2]] = e.wd;
      end else begin
         e.lat = 8'(2 + wc); e.nrd = 8'(1 + wc);
         e.rdata = extend(wrd, a, sz, sx);
         last_rdata[d2] = e.rdata;
      end
      sb.push_back(e);

      sel_d2 = d2;
      @(negedge clk);
      we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
      if (d2) start2 = 1'b1;
      else    start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start2 = 1'b0;
      check_eq({tag, " busy"}, 32'(s_busy), 32'd1);

      nrd = 0; nwr = 0; both = 1'b0; fin = 1'b0; seen_wd = '0; seen_adr = '0;
      for (cyc = 1; cyc <= 24; cyc++) begin
         if (s_mem_read)  begin nrd++; seen_adr = s_address; end
         if (s_mem_write) begin nwr++; seen_wd = s_write_data; end
         if (s_mem_read && s_mem_write) both = 1'b1;
         if (s_done) begin
            fin = 1'b1;
            break;
         end
         if (poke && cyc == 1) begin
            we = 1'b1; size = 2'd2; addr = 32'h0000_003C; wdata = 32'hFFFF_FFFF;
            if (d2) start2 = 1'b1;
            else    start0 = 1'b1;
         end
         @(negedge clk);
         start0 = 1'b0;
         start2 = 1'b0;
      end

      got = sb.pop_front();
      check_eq({tag, " done_seen"}, 32'(fin), 32'd1);
      if (!fin) return;
      check_eq({tag, " latency"}, 32'(cyc), 32'(got.lat));
      check_eq({tag, " err"}, 32'(s_err), 32'(got.err));
      check_eq({tag, " rd_cycles"}, 32'(nrd), 32'(got.nrd));
      check_eq({tag, " wr_cycles"}, 32'(nwr), 32'(got.nwr));
      check_eq({tag, " strobe_excl"}, 32'(both), 32'd0);
      if (got.nwr != 8'd0) check_eq({tag, " write_data"}, seen_wd, got.wd);
      if (got.nrd != 8'd0) check_eq({tag, " address"}, seen_adr, got.adr);
      check_eq({tag, " rdata"}, s_rdata, got.rdata);

      @(negedge clk);
      check_eq({tag, " idle_busy"}, 32'(s_busy), 32'd0);
      check_eq({tag, " idle_done"}, 32'(s_done), 32'd0);
      check_eq({tag, " rdata_held"}, s_rdata, got.rdata);
      memw = d2 ? mem2[a[5:2]] : mem0[a[5:2]];
      check_eq({tag, " mem_word"}, memw, shadow[d2][a[5:2]]);
      $display("txn %-10s dut%0d we=%0d size=%0d addr=%08h lat=%0d err=%0d rdata=%08h",
               tag, wc, w, sz, a, cyc, s_err, s_rdata);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  rsz;
      logic [31:0] ra;
      bit          rw, mw_seen;

      rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; we = 1'b0; size = 2'd0;
      sign_ext = 1'b0; addr = '0; wdata = '0; pl_en0 = 1'b0; pl_en2 = 1'b0;
      pl_idx = '0; pl_val = '0; sel_d2 = 1'b0;
      last_rdata[0] = '0; last_rdata[1] = '0;
      for (int i = 0; i < 16; i++) begin
         preload(1'b0, i, 32'd0);
         preload(1'b1, i, 32'd0);
      end

      @(negedge clk);
      check_eq("rst busy", 32'(busy0), 32'd0);
      check_eq("rst done", 32'(done0), 32'd0);
      check_eq("rst err", 32'(err0), 32'd0);
      check_eq("rst rdata", rdata0, 32'd0);
      check_eq("rst mem_read", 32'(mem_read0), 32'd0);
      check_eq("rst mem_write", 32'(mem_write0), 32'd0);
      check_eq("rst address", address0, 32'd0);
      check_eq("rst busy2", 32'(busy2), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      preload(1'b0, 1, 32'h0000_0070);
      do_req(1'b0, "LW4", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b0);

      preload(1'b0, 0, 32'h80FF_0060);
      do_req(1'b0, "LB2", 1'b0, 2'd0, 1'b1, 32'h2, 32'h0, 1'b0);
      do_req(1'b0, "LBU3", 1'b0, 2'd0, 1'b0, 32'h3, 32'h0, 1'b0);
      do_req(1'b0, "LH2", 1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 1'b0);
      do_req(1'b0, "LHU0", 1'b0, 2'd1, 1'b0, 32'h0, 32'h0, 1'b0);
      do_req(1'b0, "LB1s", 1'b0, 2'd0, 1'b1, 32'h1, 32'h0, 1'b0);

      preload(1'b0, 2, 32'h0000_0030);
      do_req(1'b0, "SB9", 1'b1, 2'd0, 1'b0, 32'h9, 32'h0000_00AB, 1'b0);
      do_req(1'b0, "LW8", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b0);
      do_req(1'b0, "SWC", 1'b1, 2'd2, 1'b0, 32'hC, 32'h1234_5678, 1'b0);
      do_req(1'b0, "SHE", 1'b1, 2'd1, 1'b0, 32'hE, 32'hCAFE_BEEF, 1'b0);
      do_req(1'b0, "LWC", 1'b0, 2'd2, 1'b1, 32'hC, 32'h0, 1'b0);

      do_req(1'b0, "LW6mis", 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 1'b0);
      do_req(1'b0, "SZ11", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
      do_req(1'b0, "LH1mis", 1'b0, 2'd1, 1'b1, 32'h1, 32'h0, 1'b0);
      do_req(1'b0, "SW2mis", 1'b1, 2'd2, 1'b0, 32'h2, 32'hDEAD_0000, 1'b0);

      for (int i = 8; i < 16; i++) preload(1'b0, i, $urandom);
      for (int i = 0; i < 16; i++) begin
         rw  = 1'($urandom_range(0, 1));
         rsz = 2'($urandom_range(0, 2));
         ra  = 32'($urandom_range(8, 15)) << 2;
         if (rsz == 2'd0) ra = ra + 32'($urandom_range(0, 3));
         if (rsz == 2'd1) ra = ra + 32'($urandom_range(0, 1) * 2);
         do_req(1'b0, $sformatf("rnd%0d", i), rw, rsz, 1'($urandom_range(0, 1)), ra, $urandom, 1'b0);
      end

      preload(1'b1, 3, 32'hDEAD_BEEF);
      do_req(1'b1, "W2LHU", 1'b0, 2'd1, 1'b0, 32'hE, 32'h0, 1'b1);
      check_eq("W2 poke mem15", mem2[15], shadow[1][15]);
      do_req(1'b1, "W2LBs", 1'b0, 2'd0, 1'b1, 32'hC, 32'h0, 1'b0);
      preload(1'b1, 4, 32'h0000_0030);
      do_req(1'b1, "W2SB", 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB, 1'b1);
      do_req(1'b1, "W2SW", 1'b1, 2'd2, 1'b0, 32'h14, 32'h0BAD_F00D, 1'b0);
      do_req(1'b1, "W2LW", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0);

      // Reset asserted while the RMW store is in its write cycle.
      preload(1'b0, 5, 32'h1122_3344);
      @(negedge clk);
      we = 1'b1; size = 2'd0; addr = 32'h15; wdata = 32'h55; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      mw_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (mem_write0) begin
            mw_seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check_eq("rstmid write_seen", 32'(mw_seen), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("rstmid mem_write", 32'(mem_write0), 32'd0);
      check_eq("rstmid busy", 32'(busy0), 32'd0);
      check_eq("rstmid done", 32'(done0), 32'd0);
      check_eq("rstmid rdata", rdata0, 32'd0);
      last_rdata[0] = 32'd0;
      last_rdata[1] = 32'd0;
      @(negedge clk);
      check_eq("rstmid mem_word", mem0[5], 32'h1122_3344);
      rst_n = 1'b1;
      do_req(1'b0, "postrst", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the word-wide data memory interface; sits between the datapath's load/store request and the data memory.
- Converts byte, halfword and word loads/stores into word-aligned memory accesses.
- Performs read-modify-write for sub-word stores; sign/zero-extends sub-word loads.
- Multi-cycle, with a start/done handshake toward the core.

Parameters:
ADDR_WIDTH, 32, width of the byte address on both sides.
WAIT_CYCLES, 0, extra cycles a read is held before read_data is sampled (0..15).

Ports:
clk  input  1  clock; all state changes on posedge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request strobe, sampled only in IDLE.
we  input  1  1 = store, 0 = load.
size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
addr  input  ADDR_WIDTH  byte address.
wdata  input  32  store data, right-justified.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle completion pulse.
err  output  1  high with done when the request was rejected.
rdata  output  32  extended load result; held until the next accepted load.
mem_read  output  1  memory read strobe.
mem_write  output  1  memory write strobe; the write commits on posedge.
address  output  ADDR_WIDTH  word-aligned address: addr with bits [1:0] forced to 00.
write_data  output  32  merged word to the memory.
read_data  input  32  combinational memory read data, valid while mem_read=1.

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, wait counter 0. mem_read and mem_write drop immediately, without waiting for clk.
- Request latching: on start in IDLE, addr, we, size, sign_ext and wdata are latched.
  - start while busy is ignored.
- States and transitions:
  - IDLE -> ERR if misaligned or size=11. Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
  - IDLE -> WRITE for a word store.
  - IDLE -> READ otherwise.
  - READ:
    - mem_read=1 and address valid.
    - Stays for WAIT_CYCLES+1 cycles.
    - On the last cycle, read_data is captured into the word register.
    - Exits to WRITE for a store, DONE for a load.
  - WRITE:
    - mem_write=1 for exactly 1 cycle, then DONE.
    - write_data is wdata for a word store; otherwise the captured word with the selected lane(s) replaced.
  - DONE: done=1 for 1 cycle, then IDLE.
  - ERR: done=1 and err=1 for 1 cycle, then IDLE. No memory strobe and rdata unchanged.
- Strobes: mem_read and mem_write are never high together.
- Byte lanes: little-endian.
  - Byte lane n = bits [8n+7:8n], with n=addr[1:0].
  - Half lane = addr[1]: 0 selects [15:0], 1 selects [31:16].
- Loads: rdata is updated on entry to DONE. The selected lane is extended per sign_ext; a word load ignores sign_ext.
- Latency from the start edge to the done pulse:
  - word store: 2 cycles.
  - load: 2+WAIT_CYCLES cycles.
  - sub-word store: 3+WAIT_CYCLES cycles.
  - error: 1 cycle.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted on the following IDLE cycle; there is no request queue.
- busy=0 in IDLE, 1 in READ, WRITE, DONE and ERR.

Test Plan:
- Reset mid-operation: assert rst_n=0 during WRITE -> mem_write falls asynchronously, busy=0, and the memory word is unchanged.
- Word load:
  - Preload word1=0x00000070; load word, addr=0x4.
  - Required: address=0x4, mem_read for 1 cycle, done 2 cycles after start, rdata=0x00000070.
- Sub-word loads:
  - Preload word0=0x80FF0060.
  - LB with sign_ext=1 at addr 0x2 -> rdata=0xFFFFFFFF.
  - LBU at addr 0x3 -> rdata=0x00000080.
  - LH with sign_ext=1 at addr 0x2 -> rdata=0xFFFF80FF.
- Byte store RMW:
  - Preload word2=0x00000030; SB wdata=0xAB at addr 0x9.
  - Required: READ, then WRITE with write_data=0x0000AB30; word2 reads back 0x0000AB30; latency 3 cycles.
- Misaligned and illegal requests:
  - LW at addr 0x6 -> err and done in the same cycle after 1 cycle, no mem strobes, rdata unchanged.
  - size=11 gives the same response.
- WAIT_CYCLES=2 with back-to-back requests:
  - mem_read is held for 3 cycles per load.
  - A start issued during busy is ignored.
  - A second load started after done completes correctly.
